// File: rtl/riscv_pkg.sv
// Shared pipeline definitions for the five-stage RISC-V core.
// Contents: register-address width, EX operand forward-select encodings and
// the hazard controller state encoding.
package riscv_pkg;

  localparam int unsigned REG_AW = 5;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_controller.
// master: pipeline side (drives register ids/handshakes, receives controls).
// slave : hazard controller side (receives ids/handshakes, drives stall,
//         flush, forward selects, fault flag and debug counters).
interface hazard_controller_if #(
  parameter int unsigned CNT_W = 32
);

  logic [riscv_pkg::REG_AW-1:0] rs1_d;
  logic [riscv_pkg::REG_AW-1:0] rs2_d;
  logic [riscv_pkg::REG_AW-1:0] rs1_e;
  logic [riscv_pkg::REG_AW-1:0] rs2_e;
  logic [riscv_pkg::REG_AW-1:0] rd_e;
  logic                         load_e;
  logic                         pcsrc_e;
  logic [riscv_pkg::REG_AW-1:0] rd_m;
  logic                         regwrite_m;
  logic [riscv_pkg::REG_AW-1:0] rd_w;
  logic                         regwrite_w;
  logic                         dmem_req_m;
  logic                         dmem_ready;
  logic                         fault_clr;

  logic                         stall_f;
  logic                         stall_d;
  logic                         stall_e;
  logic                         stall_m;
  logic                         flush_d;
  logic                         flush_e;
  logic [1:0]                   forward_a_e;
  logic [1:0]                   forward_b_e;
  logic                         mem_fault;
  logic [CNT_W-1:0]             stall_cycles;
  logic [CNT_W-1:0]             flush_events;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pcsrc_e,
           rd_m, regwrite_m, rd_w, regwrite_w,
           dmem_req_m, dmem_ready, fault_clr,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
           forward_a_e, forward_b_e, mem_fault, stall_cycles, flush_events
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pcsrc_e,
           rd_m, regwrite_m, rd_w, regwrite_w,
           dmem_req_m, dmem_ready, fault_clr,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
           forward_a_e, forward_b_e, mem_fault, stall_cycles, flush_events
  );

endinterface

// File: rtl/forward_select.sv
// Forward-select for one EX operand: the youngest in-flight writer of the
// source register wins (MEM over WB); x0 is never forwarded.
// Ports: i_rs_e source reg in EX; i_rd_m/i_regwrite_m EX/MEM writer;
//        i_rd_w/i_regwrite_w MEM/WB writer; o_fwd combinational select.
module forward_select
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_regwrite_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_w,
  output logic [1:0]        o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_MEM;
    end else if (i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch squash,
// data-memory wait freeze with timeout fault, EX forwarding, debug counters.
// Ports: clk; reset (async, active-low); hz slave bundle carrying the
//        pipeline register ids/handshakes in and stall/flush/forward
//        controls, mem_fault and the stall/flush event counters out.
module hazard_controller
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  localparam int unsigned      WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [0:0]       S_RUN     = HZ_RUN;
  localparam logic [0:0]       S_WAIT    = HZ_MEM_WAIT;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              w_timeout;
  logic              w_mem_stall;
  logic              w_lw_hz;
  logic              w_stall_f;
  logic              w_stall_d;
  logic              w_stall_e;
  logic              w_stall_m;
  logic              w_flush_d;
  logic              w_flush_e;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic              r_mem_fault;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_events;

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Memory-wait FSM; the counter is held at zero in RUN so each wait starts at 0
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout      = 1'b0;
    w_mem_stall    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_wait_cnt_nxt = '0;
        if (hz.dmem_req_m && !hz.dmem_ready) begin
          w_mem_stall = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        if (hz.dmem_ready) begin
          w_state_nxt = S_RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          // abandon the access: release the pipeline and flag the fault
          w_timeout   = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_mem_stall = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_lw_hz = hz.load_e && (hz.rd_e != '0) &&
                   ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // Priority: reset > memory freeze > taken branch > load-use.
  // A branch during the freeze is held in EX, so its flush lands after the wait.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (!reset) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
    end else if (hz.pcsrc_e) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lw_hz) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  forward_select u_fwd_a (
    .i_rs_e       (hz.rs1_e),
    .i_rd_m       (hz.rd_m),
    .i_regwrite_m (hz.regwrite_m),
    .i_rd_w       (hz.rd_w),
    .i_regwrite_w (hz.regwrite_w),
    .o_fwd        (w_fwd_a)
  );

  forward_select u_fwd_b (
    .i_rs_e       (hz.rs2_e),
    .i_rd_m       (hz.rd_m),
    .i_regwrite_m (hz.regwrite_m),
    .i_rd_w       (hz.rd_w),
    .i_regwrite_w (hz.regwrite_w),
    .o_fwd        (w_fwd_b)
  );

  // Sticky fault (set beats clear) and wrapping event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_fault    <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_timeout) begin
        r_mem_fault <= 1'b1;
      end else if (hz.fault_clr) begin
        r_mem_fault <= 1'b0;
      end
      if (w_stall_f) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_d && hz.pcsrc_e) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign hz.stall_f      = w_stall_f;
  assign hz.stall_d      = w_stall_d;
  assign hz.stall_e      = w_stall_e;
  assign hz.stall_m      = w_stall_m;
  assign hz.flush_d      = w_flush_d;
  assign hz.flush_e      = w_flush_e;
  assign hz.forward_a_e  = reset ? w_fwd_a : FWD_RF;
  assign hz.forward_b_e  = reset ? w_fwd_b : FWD_RF;
  assign hz.mem_fault    = r_mem_fault;
  assign hz.stall_cycles = r_stall_cycles;
  assign hz.flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MEM_TIMEOUT = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hazard_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  hazard_controller_if #(.CNT_W(32)) hz_if ();

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    hz_if.rs1_d = 5'd0; hz_if.rs2_d = 5'd0;
    hz_if.rs1_e = 5'd0; hz_if.rs2_e = 5'd0; hz_if.rd_e = 5'd0;
    hz_if.load_e = 1'b0; hz_if.pcsrc_e = 1'b0;
    hz_if.rd_m = 5'd0; hz_if.regwrite_m = 1'b0;
    hz_if.rd_w = 5'd0; hz_if.regwrite_w = 1'b0;
    hz_if.dmem_req_m = 1'b0; hz_if.dmem_ready = 1'b0;
    hz_if.fault_clr = 1'b0;
  endtask

  // advance through one rising edge to the next falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    hz_if.rs1_e = 5'd7; hz_if.rd_m = 5'd7; hz_if.regwrite_m = 1'b1;
    #1;
    checks++; if (hz_if.stall_f !== 1'b0) begin errors++; $display("FAIL rst_stall_f: got %b want 0", hz_if.stall_f); end
    checks++; if (hz_if.stall_m !== 1'b0) begin errors++; $display("FAIL rst_stall_m: got %b want 0", hz_if.stall_m); end
    checks++; if ({hz_if.flush_d, hz_if.flush_e} !== 2'b11) begin errors++; $display("FAIL rst_flush: got %b%b want 11", hz_if.flush_d, hz_if.flush_e); end
    checks++; if (hz_if.forward_a_e !== 2'b00) begin errors++; $display("FAIL rst_fwd_a: got %b want 00", hz_if.forward_a_e); end
    checks++; if (hz_if.mem_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", hz_if.mem_fault); end
    checks++; if (hz_if.stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", hz_if.stall_cycles); end
    checks++; if (hz_if.flush_events !== 32'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d want 0", hz_if.flush_events); end
    tick();
    set_idle();
    reset = 1'b1;
    #1;
    checks++; if ({hz_if.flush_d, hz_if.flush_e, hz_if.stall_f} !== 3'b000) begin errors++; $display("FAIL rel_idle: got %b%b%b want 000", hz_if.flush_d, hz_if.flush_e, hz_if.stall_f); end
    tick();
  endtask

  task automatic test_load_use();
    hz_if.load_e = 1'b1; hz_if.rd_e = 5'd5; hz_if.rs1_d = 5'd5;
    #1;
    checks++; if ({hz_if.stall_f, hz_if.stall_d, hz_if.flush_e} !== 3'b111) begin errors++; $display("FAIL lu_resp: got %b%b%b want 111", hz_if.stall_f, hz_if.stall_d, hz_if.flush_e); end
    checks++; if ({hz_if.flush_d, hz_if.stall_e, hz_if.stall_m} !== 3'b000) begin errors++; $display("FAIL lu_other: got %b%b%b want 000", hz_if.flush_d, hz_if.stall_e, hz_if.stall_m); end
    tick(); exp_stall++;
    hz_if.load_e = 1'b0;
    #1;
    checks++; if (hz_if.stall_f !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", hz_if.stall_f); end
    checks++; if (hz_if.stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_stall_cnt: got %0d want %0d", hz_if.stall_cycles, exp_stall); end
    // rs2 match also hazards
    hz_if.load_e = 1'b1; hz_if.rd_e = 5'd12; hz_if.rs1_d = 5'd3; hz_if.rs2_d = 5'd12;
    #1;
    checks++; if (hz_if.stall_d !== 1'b1) begin errors++; $display("FAIL lu_rs2: got %b want 1", hz_if.stall_d); end
    // load to x0 never hazards
    hz_if.rd_e = 5'd0; hz_if.rs1_d = 5'd0; hz_if.rs2_d = 5'd0;
    #1;
    checks++; if ({hz_if.stall_f, hz_if.flush_e} !== 2'b00) begin errors++; $display("FAIL lu_x0: got %b%b want 00", hz_if.stall_f, hz_if.flush_e); end
    set_idle();
    tick();
  endtask

  task automatic test_forwarding();
    hz_if.rs1_e = 5'd7; hz_if.rd_m = 5'd7; hz_if.rd_w = 5'd7;
    hz_if.regwrite_m = 1'b1; hz_if.regwrite_w = 1'b1;
    #1;
    checks++; if (hz_if.forward_a_e !== 2'b10) begin errors++; $display("FAIL fwd_mem_prio: got %b want 10", hz_if.forward_a_e); end
    hz_if.regwrite_m = 1'b0;
    #1;
    checks++; if (hz_if.forward_a_e !== 2'b01) begin errors++; $display("FAIL fwd_wb: got %b want 01", hz_if.forward_a_e); end
    hz_if.regwrite_m = 1'b1; hz_if.rd_m = 5'd0; hz_if.rd_w = 5'd0; hz_if.rs1_e = 5'd0;
    #1;
    checks++; if (hz_if.forward_a_e !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b want 00", hz_if.forward_a_e); end
    hz_if.rs2_e = 5'd9; hz_if.rd_w = 5'd9; hz_if.rd_m = 5'd3;
    #1;
    checks++; if (hz_if.forward_b_e !== 2'b01) begin errors++; $display("FAIL fwd_b_wb: got %b want 01", hz_if.forward_b_e); end
    checks++; if (hz_if.forward_a_e !== 2'b00) begin errors++; $display("FAIL fwd_a_none: got %b want 00", hz_if.forward_a_e); end
    hz_if.rd_m = 5'd9;
    #1;
    checks++; if (hz_if.forward_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_mem: got %b want 10", hz_if.forward_b_e); end
    set_idle();
    tick();
  endtask

  task automatic test_branch_over_load();
    hz_if.load_e = 1'b1; hz_if.rd_e = 5'd5; hz_if.rs1_d = 5'd5; hz_if.pcsrc_e = 1'b1;
    #1;
    checks++; if ({hz_if.flush_d, hz_if.flush_e} !== 2'b11) begin errors++; $display("FAIL br_flush: got %b%b want 11", hz_if.flush_d, hz_if.flush_e); end
    checks++; if ({hz_if.stall_f, hz_if.stall_d} !== 2'b00) begin errors++; $display("FAIL br_stall: got %b%b want 00", hz_if.stall_f, hz_if.stall_d); end
    tick(); exp_flush++;
    set_idle();
    #1;
    checks++; if (hz_if.flush_events !== exp_flush) begin errors++; $display("FAIL br_flush_cnt: got %0d want %0d", hz_if.flush_events, exp_flush); end
    checks++; if (hz_if.stall_cycles !== exp_stall) begin errors++; $display("FAIL br_stall_cnt: got %0d want %0d", hz_if.stall_cycles, exp_stall); end
    tick();
  endtask

  task automatic test_mem_wait();
    // a taken branch arriving during the freeze must be deferred
    hz_if.dmem_req_m = 1'b1; hz_if.dmem_ready = 1'b0; hz_if.pcsrc_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({hz_if.stall_f, hz_if.stall_d, hz_if.stall_e, hz_if.stall_m} !== 4'b1111) begin errors++; $display("FAIL mw_stall%0d: got %b%b%b%b want 1111", i, hz_if.stall_f, hz_if.stall_d, hz_if.stall_e, hz_if.stall_m); end
      checks++; if ({hz_if.flush_d, hz_if.flush_e} !== 2'b00) begin errors++; $display("FAIL mw_noflush%0d: got %b%b want 00", i, hz_if.flush_d, hz_if.flush_e); end
      tick(); exp_stall++;
    end
    hz_if.dmem_ready = 1'b1;
    #1;
    checks++; if ({hz_if.stall_f, hz_if.stall_m} !== 2'b00) begin errors++; $display("FAIL mw_release: got %b%b want 00", hz_if.stall_f, hz_if.stall_m); end
    checks++; if (hz_if.flush_d !== 1'b1) begin errors++; $display("FAIL mw_deferred_flush: got %b want 1", hz_if.flush_d); end
    tick(); exp_flush++;
    set_idle();
    #1;
    checks++; if (hz_if.mem_fault !== 1'b0) begin errors++; $display("FAIL mw_fault: got %b want 0", hz_if.mem_fault); end
    checks++; if (hz_if.stall_cycles !== exp_stall) begin errors++; $display("FAIL mw_stall_cnt: got %0d want %0d", hz_if.stall_cycles, exp_stall); end
    checks++; if (hz_if.flush_events !== exp_flush) begin errors++; $display("FAIL mw_flush_cnt: got %0d want %0d", hz_if.flush_events, exp_flush); end
    // request completing in its first cycle: no stall, no state change
    hz_if.dmem_req_m = 1'b1; hz_if.dmem_ready = 1'b1;
    #1;
    checks++; if (hz_if.stall_f !== 1'b0) begin errors++; $display("FAIL mw_ready_now: got %b want 0", hz_if.stall_f); end
    tick();
    hz_if.dmem_req_m = 1'b0; hz_if.dmem_ready = 1'b0;
    #1;
    checks++; if (hz_if.stall_f !== 1'b0) begin errors++; $display("FAIL mw_still_run: got %b want 0", hz_if.stall_f); end
    tick();
  endtask

  task automatic test_timeout();
    hz_if.dmem_req_m = 1'b1; hz_if.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (hz_if.stall_e !== 1'b1) begin errors++; $display("FAIL to_stall%0d: got %b want 1", i, hz_if.stall_e); end
      tick(); exp_stall++;
    end
    #1;
    checks++; if (hz_if.stall_f !== 1'b0) begin errors++; $display("FAIL to_release: got %b want 0", hz_if.stall_f); end
    checks++; if (hz_if.mem_fault !== 1'b0) begin errors++; $display("FAIL to_fault_early: got %b want 0", hz_if.mem_fault); end
    // same-cycle clear must lose to the set
    hz_if.fault_clr = 1'b1;
    tick();
    hz_if.fault_clr = 1'b0;
    hz_if.dmem_req_m = 1'b0;
    #1;
    checks++; if (hz_if.mem_fault !== 1'b1) begin errors++; $display("FAIL to_fault_set: got %b want 1", hz_if.mem_fault); end
    checks++; if (hz_if.stall_f !== 1'b0) begin errors++; $display("FAIL to_back_run: got %b want 0", hz_if.stall_f); end
    tick();
    #1;
    checks++; if (hz_if.mem_fault !== 1'b1) begin errors++; $display("FAIL to_fault_sticky: got %b want 1", hz_if.mem_fault); end
    hz_if.fault_clr = 1'b1;
    tick();
    hz_if.fault_clr = 1'b0;
    #1;
    checks++; if (hz_if.mem_fault !== 1'b0) begin errors++; $display("FAIL to_fault_clr: got %b want 0", hz_if.mem_fault); end
    checks++; if (hz_if.stall_cycles !== exp_stall) begin errors++; $display("FAIL to_stall_cnt: got %0d want %0d", hz_if.stall_cycles, exp_stall); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    hz_if.dmem_req_m = 1'b1; hz_if.dmem_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (hz_if.stall_f !== 1'b1) begin errors++; $display("FAIL rw_waiting: got %b want 1", hz_if.stall_f); end
    reset = 1'b0;
    #1;
    checks++; if ({hz_if.flush_d, hz_if.flush_e, hz_if.stall_f} !== 3'b110) begin errors++; $display("FAIL rw_forced: got %b%b%b want 110", hz_if.flush_d, hz_if.flush_e, hz_if.stall_f); end
    checks++; if (hz_if.stall_cycles !== 32'd0) begin errors++; $display("FAIL rw_stall_cnt: got %0d want 0", hz_if.stall_cycles); end
    checks++; if (hz_if.flush_events !== 32'd0) begin errors++; $display("FAIL rw_flush_cnt: got %0d want 0", hz_if.flush_events); end
    tick();
    hz_if.dmem_req_m = 1'b0;
    reset = 1'b1;
    exp_stall = 32'd0; exp_flush = 32'd0;
    #1;
    checks++; if (hz_if.stall_f !== 1'b0) begin errors++; $display("FAIL rw_state_run: got %b want 0", hz_if.stall_f); end
    tick();
    #1;
    checks++; if (hz_if.mem_fault !== 1'b0) begin errors++; $display("FAIL rw_no_fault: got %b want 0", hz_if.mem_fault); end
    checks++; if (hz_if.stall_cycles !== exp_stall) begin errors++; $display("FAIL rw_cnt_after: got %0d want %0d", hz_if.stall_cycles, exp_stall); end
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_stall = 32'd0; exp_flush = 32'd0;
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_over_load();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
